store_buffer: RTL and testbench

Posted-write buffer between the core's store port and the memory's single write port. Accepts word stores from the core in one cycle and drains them to memory in FIFO order, whenever the write port is granted. Forwards buffered data to the core's data-read port (read port 1) so loads always see the youngest store. The core can then issue stores while the memory write port is busy with another master; the core may halt only once the buffer reports empty.

---
 rtl/store_buffer_if.sv | 27 ++
 rtl/store_buffer.sv | 86 ++++++++
 tb/tb_store_buffer.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/store_buffer_if.sv
// Core store/load port and memory write/read port of the store buffer.
// master = the core/memory side, slave = the buffer itself.
interface store_buffer_if;
  logic        c_wen;
  logic [14:0] c_waddr;
  logic [15:0] c_wdata;
  logic        c_full;
  logic [14:0] c_raddr;
  logic [15:0] c_rdata;
  logic        empty;
  logic        m_wgrant;
  logic        m_wen;
  logic [14:0] m_waddr;
  logic [15:0] m_wdata;
  logic [14:0] m_raddr;
  logic [15:0] m_rdata;

  modport master (
    output c_wen, c_waddr, c_wdata, c_raddr, m_wgrant, m_rdata,
    input  c_full, c_rdata, empty, m_wen, m_waddr, m_wdata, m_raddr
  );

  modport slave (
    input  c_wen, c_waddr, c_wdata, c_raddr, m_wgrant, m_rdata,
    output c_full, c_rdata, empty, m_wen, m_waddr, m_wdata, m_raddr
  );
endinterface

// File: rtl/store_buffer.sv
// Posted-write FIFO between the core store port and the shared memory write port,
// with store merging into the youngest entry and load forwarding from buffered stores.
module store_buffer #(
  parameter int DEPTH = 4
) (
  input logic          clk,
  input logic          reset,
  store_buffer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_CNT  = (AW+1)'(1);

  logic [14:0]   addr_q [DEPTH];
  logic [15:0]   data_q [DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [AW-1:0] youngest;
  logic [AW:0]   count;

  logic          pop;
  logic          merge;
  logic          alloc;
  logic          hit_c;
  logic [15:0]   data_c;
  logic [AW-1:0] idx;
  logic          fwd_hit;
  logic [15:0]   fwd_data;

  assign youngest = tail - AW'(1);

  // No drain in a reset cycle: entries are being discarded, not written.
  assign pop = (count != '0) && bus.m_wgrant && !reset;

  // The youngest entry can only be the one draining when it is also the only one.
  assign merge = bus.c_wen && (count != '0) && (addr_q[youngest] == bus.c_waddr)
                 && !(pop && (count == ONE_CNT));
  assign alloc = bus.c_wen && !merge && (count != FULL_CNT);

  // Scan oldest to youngest so the last match wins; draining head is still visible.
  always_comb begin
    hit_c  = 1'b0;
    data_c = '0;
    idx    = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + AW'(k);
      if (((AW+1)'(k) < count) && (addr_q[idx] == bus.c_raddr)) begin
        hit_c  = 1'b1;
        data_c = data_q[idx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      fwd_hit  <= 1'b0;
      fwd_data <= '0;
    end else begin
      if (pop) begin
        head <= head + AW'(1);
      end
      if (merge) begin
        data_q[youngest] <= bus.c_wdata;
      end
      if (alloc) begin
        addr_q[tail] <= bus.c_waddr;
        data_q[tail] <= bus.c_wdata;
        tail         <= tail + AW'(1);
      end
      count    <= count + (AW+1)'(alloc) - (AW+1)'(pop);
      fwd_hit  <= hit_c;
      fwd_data <= data_c;
    end
  end

  assign bus.m_wen   = pop;
  assign bus.m_waddr = (count != '0) ? addr_q[head] : '0;
  assign bus.m_wdata = (count != '0) ? data_q[head] : '0;
  assign bus.m_raddr = bus.c_raddr;
  assign bus.c_full  = (count == FULL_CNT);
  assign bus.empty   = (count == '0);
  assign bus.c_rdata = fwd_hit ? fwd_data : bus.m_rdata;
endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: directed vector table, mid-operation reset, wrap test and
// random traffic, all checked against a queue-based reference model.
module tb_store_buffer;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset;
  store_buffer_if sb();

  store_buffer #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (sb.slave)
  );

  always #5 clk = ~clk;

  // Memory the DUT talks to: read-before-write on a same-address collision.
  bit [15:0] mem [32768];
  always @(posedge clk) begin
    sb.m_rdata <= mem[sb.m_raddr];
    if (sb.m_wen === 1'b1) mem[sb.m_waddr] <= sb.m_wdata;
  end

  typedef struct {
    logic [14:0] a;
    logic [15:0] d;
  } ent_t;

  typedef struct {
    bit          r;
    bit          wen;
    logic [14:0] wa;
    logic [15:0] wd;
    logic [14:0] ra;
    bit          g;
    bit          e_wen;
    logic [14:0] e_wa;
    logic [15:0] e_wd;
    bit          e_full;
    bit          e_empty;
    bit          c_rd;
    logic [15:0] e_rd;
  } row_t;

  ent_t        q[$];
  ent_t        wlog[$];
  bit [15:0]   ref_mem [32768];
  row_t        rows[$];
  int          errors = 0;
  int          checks = 0;
  int          violations = 0;
  bit          check_en = 1'b0;
  bit          rd_known = 1'b0;
  logic [15:0] exp_rd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit r, input bit wen, input logic [14:0] wa,
                       input logic [15:0] wd, input logic [14:0] ra, input bit g);
    reset       = r;
    sb.c_wen    = wen;
    sb.c_waddr  = wa;
    sb.c_wdata  = wd;
    sb.c_raddr  = ra;
    sb.m_wgrant = g;
  endtask

  task automatic model_check();
    bit ew;
    ew = (q.size() != 0) && sb.m_wgrant && !reset;
    chk("m_wen", 32'(sb.m_wen), 32'(ew));
    if (ew) begin
      chk("m_waddr", 32'(sb.m_waddr), 32'(q[0].a));
      chk("m_wdata", 32'(sb.m_wdata), 32'(q[0].d));
    end
    chk("c_full", 32'(sb.c_full), 32'(q.size() == DEPTH));
    chk("empty", 32'(sb.empty), 32'(q.size() == 0));
    chk("m_raddr", 32'(sb.m_raddr), 32'(sb.c_raddr));
    if (rd_known) chk("c_rdata", 32'(sb.c_rdata), 32'(exp_rd));
  endtask

  task automatic model_update();
    bit hit, pop, mrg, alc;
    logic [15:0] hd;
    hit = 1'b0;
    hd  = '0;
    if (reset) begin
      q.delete();
      exp_rd = ref_mem[sb.c_raddr];
    end else begin
      for (int i = q.size() - 1; i >= 0; i--) begin
        if (!hit && q[i].a == sb.c_raddr) begin
          hit = 1'b1;
          hd  = q[i].d;
        end
      end
      exp_rd = hit ? hd : ref_mem[sb.c_raddr];
      pop = (q.size() != 0) && sb.m_wgrant;
      mrg = sb.c_wen && (q.size() != 0) && (q[$].a == sb.c_waddr) && !(pop && q.size() == 1);
      alc = sb.c_wen && !mrg && (q.size() < DEPTH);
      if (sb.c_wen && !mrg && !alc) violations++;
      if (pop) begin
        ref_mem[q[0].a] = q[0].d;
        void'(q.pop_front());
      end
      if (mrg) q[$].d = sb.c_wdata;
      if (alc) q.push_back('{a: sb.c_waddr, d: sb.c_wdata});
    end
    rd_known = 1'b1;
  endtask

  // Called at the falling edge; finishes the cycle and returns #1 after the rising edge.
  task automatic finish_cycle();
    if (check_en) model_check();
    if (sb.m_wen === 1'b1) wlog.push_back('{a: sb.m_waddr, d: sb.m_wdata});
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    @(negedge clk);
    finish_cycle();
  endtask

  function automatic row_t mk(bit r, bit wen, logic [14:0] wa, logic [15:0] wd,
                              logic [14:0] ra, bit g, bit e_wen, logic [14:0] e_wa,
                              logic [15:0] e_wd, bit e_full, bit e_empty,
                              bit c_rd, logic [15:0] e_rd);
    row_t t;
    t = '{r: r, wen: wen, wa: wa, wd: wd, ra: ra, g: g, e_wen: e_wen, e_wa: e_wa,
          e_wd: e_wd, e_full: e_full, e_empty: e_empty, c_rd: c_rd, e_rd: e_rd};
    return t;
  endfunction

  initial begin
    int sent;
    int start;
    int cyc;
    bit wen;
    logic [14:0] wa;

    //               r  w  waddr     wdata     raddr     g  ewen ewaddr    ewdata    full empty crd erd
    rows.push_back(mk(1, 1, 15'h0007, 16'hFFFF, 15'h0000, 1, 0, 15'h0000, 16'h0000, 0, 1, 0, 16'h0000));
    rows.push_back(mk(0, 0, 15'h0000, 16'h0000, 15'h0000, 1, 0, 15'h0000, 16'h0000, 0, 1, 0, 16'h0000));
    rows.push_back(mk(0, 1, 15'h0010, 16'h1234, 15'h0000, 1, 0, 15'h0000, 16'h0000, 0, 1, 0, 16'h0000));
    rows.push_back(mk(0, 0, 15'h0000, 16'h0000, 15'h0000, 1, 1, 15'h0010, 16'h1234, 0, 0, 0, 16'h0000));
    rows.push_back(mk(0, 0, 15'h0000, 16'h0000, 15'h0000, 0, 0, 15'h0000, 16'h0000, 0, 1, 0, 16'h0000));
    rows.push_back(mk(0, 1, 15'h0001, 16'hA001, 15'h0010, 0, 0, 15'h0000, 16'h0000, 0, 1, 0, 16'h0000));
    rows.push_back(mk(0, 1, 15'h0002, 16'hA002, 15'h0000, 0, 0, 15'h0000, 16'h0000, 0, 0, 1, 16'h1234));
    rows.push_back(mk(0, 1, 15'h0003, 16'hA003, 15'h0000, 0, 0, 15'h0000, 16'h0000, 0, 0, 0, 16'h0000));
    rows.push_back(mk(0, 1, 15'h0004, 16'hA004, 15'h0000, 0, 0, 15'h0000, 16'h0000, 0, 0, 0, 16'h0000));
    rows.push_back(mk(0, 1, 15'h0005, 16'hDEAD, 15'h0000, 0, 0, 15'h0000, 16'h0000, 1, 0, 0, 16'h0000));
    rows.push_back(mk(0, 1, 15'h0004, 16'hBEEF, 15'h0000, 0, 0, 15'h0000, 16'h0000, 1, 0, 0, 16'h0000));
    rows.push_back(mk(0, 0, 15'h0000, 16'h0000, 15'h0000, 1, 1, 15'h0001, 16'hA001, 1, 0, 0, 16'h0000));
    rows.push_back(mk(0, 0, 15'h0000, 16'h0000, 15'h0000, 1, 1, 15'h0002, 16'hA002, 0, 0, 0, 16'h0000));
    rows.push_back(mk(0, 0, 15'h0000, 16'h0000, 15'h0000, 1, 1, 15'h0003, 16'hA003, 0, 0, 0, 16'h0000));
    rows.push_back(mk(0, 0, 15'h0000, 16'h0000, 15'h0000, 1, 1, 15'h0004, 16'hBEEF, 0, 0, 0, 16'h0000));
    rows.push_back(mk(0, 0, 15'h0000, 16'h0000, 15'h0004, 1, 0, 15'h0000, 16'h0000, 0, 1, 0, 16'h0000));
    rows.push_back(mk(0, 1, 15'h0008, 16'h1111, 15'h0000, 0, 0, 15'h0000, 16'h0000, 0, 1, 1, 16'hBEEF));
    rows.push_back(mk(0, 1, 15'h0008, 16'h2222, 15'h0000, 0, 0, 15'h0000, 16'h0000, 0, 0, 0, 16'h0000));
    rows.push_back(mk(0, 0, 15'h0000, 16'h0000, 15'h0008, 0, 0, 15'h0000, 16'h0000, 0, 0, 0, 16'h0000));
    rows.push_back(mk(0, 0, 15'h0000, 16'h0000, 15'h0009, 0, 0, 15'h0000, 16'h0000, 0, 0, 1, 16'h2222));
    rows.push_back(mk(0, 0, 15'h0000, 16'h0000, 15'h0000, 0, 0, 15'h0000, 16'h0000, 0, 0, 1, 16'h0000));
    rows.push_back(mk(0, 0, 15'h0000, 16'h0000, 15'h0000, 1, 1, 15'h0008, 16'h2222, 0, 0, 1, 16'h0000));
    rows.push_back(mk(0, 1, 15'h0020, 16'h5555, 15'h0000, 0, 0, 15'h0000, 16'h0000, 0, 1, 0, 16'h0000));
    rows.push_back(mk(0, 0, 15'h0000, 16'h0000, 15'h0020, 1, 1, 15'h0020, 16'h5555, 0, 0, 0, 16'h0000));
    rows.push_back(mk(0, 0, 15'h0000, 16'h0000, 15'h0000, 0, 0, 15'h0000, 16'h0000, 0, 1, 1, 16'h5555));
    rows.push_back(mk(0, 1, 15'h0030, 16'h0001, 15'h0000, 0, 0, 15'h0000, 16'h0000, 0, 1, 0, 16'h0000));
    rows.push_back(mk(0, 1, 15'h0030, 16'h0002, 15'h0000, 1, 1, 15'h0030, 16'h0001, 0, 0, 0, 16'h0000));
    rows.push_back(mk(0, 0, 15'h0000, 16'h0000, 15'h0000, 1, 1, 15'h0030, 16'h0002, 0, 0, 0, 16'h0000));
    rows.push_back(mk(0, 0, 15'h0000, 16'h0000, 15'h0000, 1, 0, 15'h0000, 16'h0000, 0, 1, 0, 16'h0000));

    drive(1, 1, 15'h0007, 16'hFFFF, 15'h0000, 1);
    tick();
    check_en = 1'b1;

    foreach (rows[i]) begin
      drive(rows[i].r, rows[i].wen, rows[i].wa, rows[i].wd, rows[i].ra, rows[i].g);
      @(negedge clk);
      chk($sformatf("row%0d_m_wen", i), 32'(sb.m_wen), 32'(rows[i].e_wen));
      if (rows[i].e_wen) begin
        chk($sformatf("row%0d_m_waddr", i), 32'(sb.m_waddr), 32'(rows[i].e_wa));
        chk($sformatf("row%0d_m_wdata", i), 32'(sb.m_wdata), 32'(rows[i].e_wd));
      end
      chk($sformatf("row%0d_c_full", i), 32'(sb.c_full), 32'(rows[i].e_full));
      chk($sformatf("row%0d_empty", i), 32'(sb.empty), 32'(rows[i].e_empty));
      if (rows[i].c_rd) chk($sformatf("row%0d_c_rdata", i), 32'(sb.c_rdata), 32'(rows[i].e_rd));
      finish_cycle();
    end

    // Reset with three entries pending: nothing may reach memory.
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 15'h0040 + 15'(i), 16'h7000 + 16'(i), 15'h0000, 0);
      tick();
    end
    start = wlog.size();
    drive(1, 1, 15'h0050, 16'h7777, 15'h0000, 1);
    @(negedge clk);
    chk("rst_mid_m_wen", 32'(sb.m_wen), 32'd0);
    finish_cycle();
    drive(0, 0, 15'h0000, 16'h0000, 15'h0040, 1);
    @(negedge clk);
    chk("rst_mid_empty", 32'(sb.empty), 32'd1);
    finish_cycle();
    chk("rst_mid_no_write", 32'(wlog.size() - start), 32'd0);

    // Wrap: 20 stores with grant toggling every cycle.
    start = wlog.size();
    sent  = 0;
    cyc   = 0;
    while ((sent < 20 || q.size() != 0) && cyc < 200) begin
      wen = (sent < 20) && (q.size() < DEPTH);
      drive(0, wen, 15'h0100 + 15'(sent), 16'hC000 + 16'(sent), 15'h0100 + 15'(sent), cyc[0]);
      tick();
      if (wen) sent++;
      cyc++;
    end
    chk("wrap_write_count", 32'(wlog.size() - start), 32'd20);
    for (int i = 0; i < 20; i++) begin
      if (start + i < wlog.size()) begin
        chk($sformatf("wrap_addr%0d", i), 32'(wlog[start + i].a), 32'(15'h0100 + 15'(i)));
        chk($sformatf("wrap_data%0d", i), 32'(wlog[start + i].d), 32'(16'hC000 + 16'(i)));
      end
    end

    // Random traffic over a small address set to exercise merges and forwarding hits.
    for (int n = 0; n < 3000; n++) begin
      wen = 1'($urandom);
      wa  = 15'($urandom_range(0, 7));
      if (q.size() == DEPTH && q[$].a != wa) wen = 1'b0;
      drive($urandom_range(0, 99) == 0, wen, wa, 16'($urandom),
            15'($urandom_range(0, 7)), $urandom_range(0, 2) != 0);
      tick();
    end

    drive(0, 0, 15'h0000, 16'h0000, 15'h0000, 1);
    cyc = 0;
    while (q.size() != 0 && cyc < 50) begin
      tick();
      cyc++;
    end
    chk("final_drained", 32'(q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end
endmodule
